// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32 datapath with one shared ALU and one memory port.
// Adds a memory ready handshake with a wait-state timeout and halts on unsupported opcodes.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT   = 15,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       Illegal,
  output logic       MemFault,
  output logic [3:0] State
);

  // state    | meaning                       state    | meaning
  // FETCH    | read instr at PC, PC += 4     EXECR    | R-type ALU op
  // DECODE   | read regs, branch target      EXECI    | I-type ALU op
  // MEMADR   | rs1 + imm address             ALUWB    | write ALUOut to rd
  // MEMREAD  | load access                   BEQ      | compare, branch on Zero
  // MEMWB    | write load data to rd         JAL      | jump, PC+4 into ALUOut
  // MEMWRITE | store access                  HALT     | stopped until rst
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_RTYPE = 7'd51;
  localparam logic [6:0] OP_ITYPE = 7'd19;
  localparam logic [6:0] OP_BEQ   = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;

  // Counter holds completed wait cycles; the last allowed one is WAIT_LIMIT-1 before timeout.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic       mem_state;
  logic       timeout;
  logic       illegal_set;
  logic       fault_set;
  logic       pc_update;
  logic       branch;
  logic       ir_load;
  logic       mem_wr;
  logic       reg_wr;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt   = state;
    wait_nxt    = '0;
    illegal_set = 1'b0;
    fault_set   = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_load     = 1'b0;
    mem_wr      = 1'b0;
    reg_wr      = 1'b0;
    MemReq      = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ImmSrc      = 3'b111;

    if (mem_state && !mem_ready && !timeout) begin
      wait_nxt = wait_cnt + 4'd1;
    end

    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_update = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          fault_set = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BEQ:            state_nxt = S_BEQ;
          OP_JAL:            state_nxt = S_JAL;
          default: begin
            illegal_set = 1'b1;
            state_nxt   = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_STORE) begin
          ImmSrc    = 3'b010;
          state_nxt = S_MEMWRITE;
        end else begin
          ImmSrc    = 3'b000;
          state_nxt = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end else if (timeout) begin
          fault_set = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) begin
          mem_wr    = 1'b1;
          state_nxt = S_FETCH;
        end else if (timeout) begin
          fault_set = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_EXECR: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ImmSrc    = 3'b000;
        ALUOp     = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ImmSrc    = 3'b100;
        pc_update = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Write strobes are masked by rst so an access abandoned by reset never commits.
  assign IRWrite  = ir_load & ~rst;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~rst;
  assign MemWrite = mem_wr & ~rst;
  assign RegWrite = reg_wr & ~rst;
  assign State    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      Illegal  <= 1'b0;
      MemFault <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (illegal_set) Illegal <= 1'b1;
      if (fault_set) MemFault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle table, corner-case sequences and
// randomized instruction streams checked against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int WAIT_LIMIT = 15;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BEQ = 9,
                 S_JAL = 10, S_HALT = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] op = 7'd0;

  // {MemReq,AdrSrc,IRWrite,PCWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,Illegal,MemFault,State}
  wire [22:0] obs_a;
  wire [22:0] obs_b;

  int checks = 0;
  int errors = 0;
  logic exp_ill = 1'b0;
  logic exp_flt = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT), .ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .MemReq(obs_a[22]), .AdrSrc(obs_a[21]), .IRWrite(obs_a[20]), .PCWrite(obs_a[19]),
    .MemWrite(obs_a[18]), .RegWrite(obs_a[17]), .ResultSrc(obs_a[16:15]),
    .ALUSrcA(obs_a[14:13]), .ALUSrcB(obs_a[12:11]), .ALUOp(obs_a[10:9]),
    .ImmSrc(obs_a[8:6]), .Illegal(obs_a[5]), .MemFault(obs_a[4]), .State(obs_a[3:0])
  );

  multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT), .ILLEGAL_HALT(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .MemReq(obs_b[22]), .AdrSrc(obs_b[21]), .IRWrite(obs_b[20]), .PCWrite(obs_b[19]),
    .MemWrite(obs_b[18]), .RegWrite(obs_b[17]), .ResultSrc(obs_b[16:15]),
    .ALUSrcA(obs_b[14:13]), .ALUSrcB(obs_b[12:11]), .ALUOp(obs_b[10:9]),
    .ImmSrc(obs_b[8:6]), .Illegal(obs_b[5]), .MemFault(obs_b[4]), .State(obs_b[3:0])
  );

  typedef struct {
    logic       r;
    logic [6:0] o;
    logic       rdy;
    logic       z;
    logic [3:0] st;
    logic       rw, pw, mw, irw;
    logic [1:0] rs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int r, int o, int rdy, int z, int st, int rw, int pw, int mw,
                              int irw, int rs);
    vec_t v;
    v.r = 1'(r); v.o = 7'(o); v.rdy = 1'(rdy); v.z = 1'(z); v.st = 4'(st);
    v.rw = 1'(rw); v.pw = 1'(pw); v.mw = 1'(mw); v.irw = 1'(irw); v.rs = 2'(rs);
    return v;
  endfunction

  // Output values each state must show, taken from the state/output listing.
  function automatic logic [22:0] expv(int st, logic [6:0] o, logic rdy, logic z,
                                       logic ill, logic flt);
    logic       memreq = 1'b0, adr = 1'b0, irw = 1'b0, pcw = 1'b0, mw = 1'b0, rw = 1'b0;
    logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00, ao = 2'b00;
    logic [2:0] imm = 3'b111;
    case (st)
      S_FETCH:    begin memreq = 1'b1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; imm = 3'b011; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; imm = (o == 7'd35) ? 3'b010 : 3'b000; end
      S_MEMREAD:  begin memreq = 1'b1; adr = 1'b1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      S_MEMWRITE: begin memreq = 1'b1; adr = 1'b1; mw = rdy; end
      S_EXECR:    begin sa = 2'b10; ao = 2'b10; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; imm = 3'b000; ao = 2'b10; end
      S_ALUWB:    rw = 1'b1;
      S_BEQ:      begin sa = 2'b10; ao = 2'b01; pcw = z; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; imm = 3'b100; pcw = 1'b1; end
      default:    ;
    endcase
    return {memreq, adr, irw, pcw, mw, rw, rs, sa, sb, ao, imm, ill, flt, 4'(st)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [6:0] o, input logic rdy, input logic z);
    op = o; mem_ready = rdy; Zero = z;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    adv();
    rst = 1'b0;
    exp_ill = 1'b0;
    exp_flt = 1'b0;
  endtask

  task automatic step(input int st, input logic [6:0] o, input logic rdy, input logic z);
    drv(o, rdy, z);
    @(negedge clk);
    check($sformatf("model st%0d op%0d", st, o), 32'(obs_a),
          32'(expv(st, o, rdy, z, exp_ill, exp_flt)));
    adv();
  endtask

  // One memory access: 'waits' cycles without ready, then completion unless the limit hits.
  task automatic mem_access(input int st, input logic [6:0] o, input int waits,
                            output bit faulted);
    faulted = 1'b0;
    for (int k = 0; k < waits; k++) begin
      step(st, o, 1'b0, 1'($urandom));
      if (k + 1 == WAIT_LIMIT) begin
        faulted = 1'b1;
        exp_flt = 1'b1;
        break;
      end
    end
    if (!faulted) step(st, o, 1'b1, 1'($urandom));
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(13, 16));
    return int'($urandom_range(0, 3));
  endfunction

  task automatic run_instr(input logic [6:0] o);
    bit halted;
    mem_access(S_FETCH, o, rand_wait(), halted);
    if (!halted) begin
      step(S_DECODE, o, 1'($urandom), 1'($urandom));
      case (o)
        7'd3: begin
          step(S_MEMADR, o, 1'($urandom), 1'($urandom));
          mem_access(S_MEMREAD, o, rand_wait(), halted);
          if (!halted) step(S_MEMWB, o, 1'($urandom), 1'($urandom));
        end
        7'd35: begin
          step(S_MEMADR, o, 1'($urandom), 1'($urandom));
          mem_access(S_MEMWRITE, o, rand_wait(), halted);
        end
        7'd51: begin
          step(S_EXECR, o, 1'($urandom), 1'($urandom));
          step(S_ALUWB, o, 1'($urandom), 1'($urandom));
        end
        7'd19: begin
          step(S_EXECI, o, 1'($urandom), 1'($urandom));
          step(S_ALUWB, o, 1'($urandom), 1'($urandom));
        end
        7'd99: step(S_BEQ, o, 1'($urandom), 1'($urandom));
        7'd111: begin
          step(S_JAL, o, 1'($urandom), 1'($urandom));
          step(S_ALUWB, o, 1'($urandom), 1'($urandom));
        end
        default: begin
          exp_ill = 1'b1;
          halted  = 1'b1;
        end
      endcase
    end
    if (halted) begin
      step(S_HALT, o, 1'($urandom), 1'($urandom));
      step(S_HALT, o, 1'($urandom), 1'($urandom));
      do_reset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal_ops [6] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};
    logic [6:0] bad_ops   [5] = '{7'h7F, 7'h00, 7'h37, 7'h17, 7'h67};

    // reset, add, beq taken/not taken, lw with 3 waits, jal, fetch wait + sw, addi
    tbl.push_back(mk(1, 51, 1, 0, S_FETCH,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 51, 1, 0, S_FETCH,    0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 51, 1, 0, S_DECODE,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 51, 1, 0, S_EXECR,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 51, 1, 0, S_ALUWB,    1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 99, 1, 1, S_FETCH,    0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 99, 1, 1, S_DECODE,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 99, 1, 1, S_BEQ,      0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 99, 1, 0, S_FETCH,    0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 99, 1, 0, S_DECODE,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 99, 1, 0, S_BEQ,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  1, 0, S_FETCH,    0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 3,  1, 0, S_DECODE,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  1, 0, S_MEMADR,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  0, 0, S_MEMREAD,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  0, 0, S_MEMREAD,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  0, 0, S_MEMREAD,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  1, 0, S_MEMREAD,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  1, 0, S_MEMWB,    1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 111, 1, 1, S_FETCH,   0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 111, 1, 1, S_DECODE,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 111, 1, 1, S_JAL,     0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 111, 1, 1, S_ALUWB,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 35, 0, 1, S_FETCH,    0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 35, 1, 0, S_FETCH,    0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 35, 1, 0, S_DECODE,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 35, 1, 0, S_MEMADR,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 35, 0, 0, S_MEMWRITE, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 35, 1, 0, S_MEMWRITE, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 19, 1, 0, S_FETCH,    0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 19, 1, 0, S_DECODE,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 19, 1, 0, S_EXECI,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 19, 1, 0, S_ALUWB,    1, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drv(7'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("reset state", 32'(obs_a), 32'(expv(S_FETCH, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    adv();

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      drv(tbl[i].o, tbl[i].rdy, tbl[i].z);
      @(negedge clk);
      if (!tbl[i].r)
        check($sformatf("vec%0d", i),
              32'({obs_a[3:0], obs_a[17], obs_a[19], obs_a[18], obs_a[20], obs_a[16:15]}),
              32'({tbl[i].st, tbl[i].rw, tbl[i].pw, tbl[i].mw, tbl[i].irw, tbl[i].rs}));
      adv();
    end
    rst = 1'b0;

    // sw with memory never ready: 15 wait cycles, then HALT with MemFault
    do_reset();
    drv(7'd35, 1'b1, 1'b0); adv();
    drv(7'd35, 1'b1, 1'b0); adv();
    drv(7'd35, 1'b1, 1'b0); adv();
    for (int k = 0; k < WAIT_LIMIT; k++) begin
      drv(7'd35, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("sw wait%0d", k), 32'({obs_a[3:0], obs_a[18], obs_a[4]}),
            32'({4'(S_MEMWRITE), 1'b0, 1'b0}));
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      drv(7'd35, 1'b1, 1'b1);
      @(negedge clk);
      check("sw timeout halt", 32'({obs_a[3:0], obs_a[4], obs_a[18], obs_a[22]}),
            32'({4'(S_HALT), 1'b1, 1'b0, 1'b0}));
      adv();
    end

    // illegal opcode: halting instance stops, nop instance returns to FETCH
    do_reset();
    drv(7'h7F, 1'b1, 1'b0); adv();
    drv(7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    check("nop decode", 32'(obs_b), 32'(expv(S_DECODE, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0)));
    adv();
    drv(7'h7F, 1'b0, 1'b0);
    @(negedge clk);
    check("illegal halt", 32'({obs_a[3:0], obs_a[5], obs_a[17], obs_a[18]}),
          32'({4'(S_HALT), 1'b1, 1'b0, 1'b0}));
    check("illegal nop fetch", 32'(obs_b), 32'(expv(S_FETCH, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b0)));
    adv();
    for (int k = 0; k < 4; k++) begin
      int sts [4] = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
      drv(7'd51, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("nop add %0d", k), 32'(obs_b),
            32'(expv(sts[k], 7'd51, 1'b1, 1'b0, 1'b1, 1'b0)));
      check("halt holds", 32'({obs_a[3:0], obs_a[5]}), 32'({4'(S_HALT), 1'b1}));
      adv();
    end

    // rst while halted clears the sticky flags
    rst = 1'b1; adv(); rst = 1'b0;
    drv(7'd35, 1'b0, 1'b0);
    @(negedge clk);
    check("rst from halt", 32'({obs_a[3:0], obs_a[5], obs_a[4]}), 32'({4'(S_FETCH), 2'b00}));
    adv();

    // rst during a store wait: no write in the rst cycle, clean FETCH afterwards
    drv(7'd35, 1'b1, 1'b0); adv();
    drv(7'd35, 1'b1, 1'b0); adv();
    drv(7'd35, 1'b1, 1'b0); adv();
    drv(7'd35, 1'b0, 1'b0); adv();
    drv(7'd35, 1'b0, 1'b0); adv();
    rst = 1'b1;
    drv(7'd35, 1'b1, 1'b0);
    @(negedge clk);
    check("rst cycle no write", 32'(obs_a[18]), 32'(1'b0));
    adv();
    rst = 1'b0;
    drv(7'd35, 1'b0, 1'b0);
    @(negedge clk);
    check("after rst", 32'({obs_a[3:0], obs_a[18], obs_a[4], obs_a[5]}),
          32'({4'(S_FETCH), 3'b000}));
    adv();

    // randomized instruction stream against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      if ($urandom_range(0, 14) == 0) o = bad_ops[$urandom_range(0, 4)];
      else o = legal_ops[$urandom_range(0, 5)];
      run_instr(o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
